// File: rtl/node_fetch_arbiter.sv
// node_fetch_arbiter
//
// Round-robin read arbiter for the shared single-port tree-node memory
// of a decision-tree array. Each branch stage asks for the node word of
// its current node index. One read is issued per cycle, and the returned
// word is routed back with a one-hot response valid. A host configuration
// write port shares the same memory and always beats the readers. The
// memRdy qualifier tells stages that no write is still settling in the
// read path.
//
// Ports
//   clk, rst  : single clock; synchronous active-high reset
//   req       : per-stage read request, held until granted
//   reqIdx    : flattened node indices, requester i at [i*IDX_W +: IDX_W]
//   gnt       : one-hot accept, combinational, same cycle as the issue
//   rspVal    : one-hot, single-cycle response valid (registered)
//   rspData   : node word broadcast to all stages, meaningful with rspVal
//   memRdy    : high when no config write happened in the last MEM_LAT+1 cycles
//   cfgWe/cfgAddr/cfgData : host write port
//   memRd/memWe/memAddr/memWData : memory command (combinational)
//   memRData  : memory read data, valid MEM_LAT cycles after memRd
//   memStall  : memory busy, nothing is issued while high
module node_fetch_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 4,
  parameter int NODE_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*IDX_W-1:0] reqIdx,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       rspVal,
  output logic [NODE_W-1:0]        rspData,
  output logic                     memRdy,
  input  logic                     cfgWe,
  input  logic [IDX_W-1:0]         cfgAddr,
  input  logic [NODE_W-1:0]        cfgData,
  output logic                     memRd,
  output logic                     memWe,
  output logic [IDX_W-1:0]         memAddr,
  output logic [NODE_W-1:0]        memWData,
  input  logic [NODE_W-1:0]        memRData,
  input  logic                     memStall
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MEM_LAT + 2);
  localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_RST  = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(MEM_LAT + 1);

  logic [PTR_W-1:0]   lastGnt;
  logic [PTR_W-1:0]   gntIdx;
  logic               found;
  logic [PTR_W:0]     candSum;
  logic               tagVal [MEM_LAT+1];
  logic [NUM_REQ-1:0] tagId  [MEM_LAT+1];
  logic [CNT_W-1:0]   rdyCnt;

  // Round-robin search: walk the requesters starting just after the last
  // grant, wrapping at NUM_REQ, and keep the first one found. The sum is one
  // bit wider than the pointer so a single conditional subtract does the wrap
  // even when NUM_REQ is not a power of two.
  always_comb begin
    found   = 1'b0;
    gntIdx  = lastGnt;
    candSum = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      candSum = {1'b0, lastGnt} + (PTR_W+1)'(k);
      if (candSum >= NUM_REQ_W) begin
        candSum = candSum - NUM_REQ_W;
      end
      if (!found && req[candSum[PTR_W-1:0]]) begin
        found  = 1'b1;
        gntIdx = candSum[PTR_W-1:0];
      end
    end
  end

  // Issue decision. Reset and stall block everything, then the host write
  // wins over any read. Idle cycles drive a zero address and zero data so
  // the memory bus is quiet.
  always_comb begin
    gnt      = '0;
    memRd    = 1'b0;
    memWe    = 1'b0;
    memAddr  = '0;
    memWData = '0;
    if (!rst && !memStall) begin
      if (cfgWe) begin
        memWe    = 1'b1;
        memAddr  = cfgAddr;
        memWData = cfgData;
      end else if (found) begin
        gnt[gntIdx] = 1'b1;
        memRd       = 1'b1;
        memAddr     = reqIdx[gntIdx*IDX_W +: IDX_W];
      end
    end
  end

  // Pointer, tag pipeline, response capture and write-settle counter.
  // A tag enters stage 0 on the edge after its grant. It therefore sits in
  // stage MEM_LAT-1 during the cycle memRData is valid, and that is when the
  // data is captured. Reset drops every in-flight tag, so no response follows
  // a read that was interrupted.
  always_ff @(posedge clk) begin
    if (rst) begin
      lastGnt <= LAST_RST;
      for (int i = 0; i <= MEM_LAT; i++) begin
        tagVal[i] <= 1'b0;
        tagId[i]  <= '0;
      end
      rspData <= '0;
      rdyCnt  <= '0;
    end else begin
      if (memRd) begin
        lastGnt <= gntIdx;
      end
      tagVal[0] <= |gnt;
      tagId[0]  <= gnt;
      for (int i = 1; i <= MEM_LAT; i++) begin
        tagVal[i] <= tagVal[i-1];
        tagId[i]  <= tagId[i-1];
      end
      if (tagVal[MEM_LAT-1]) begin
        rspData <= memRData;
      end
      if (memWe) begin
        rdyCnt <= CNT_LOAD;
      end else if (rdyCnt != '0) begin
        rdyCnt <= rdyCnt - CNT_W'(1);
      end
    end
  end

  // The last tag stage is the registered response valid.
  assign rspVal = tagVal[MEM_LAT] ? tagId[MEM_LAT] : '0;
  assign memRdy = (rdyCnt == '0);

endmodule

// File: doc/node_fetch_arbiter.md
# node_fetch_arbiter

Round-robin arbiter that shares one single-port tree-node memory among the `internal_branch_stage_fixed` instances of a decision-tree array. Each stage requests the node word (feature index and threshold) for its current node index, and the arbiter issues one memory read per cycle. The returned word goes back to the granted stage with a one-hot valid. A host configuration write port to the same memory is multiplexed in with absolute priority. The block also generates the `memRdy` qualifier that the branch stages consume.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesting branch stages (2..16).
- `IDX_W`, 4: node index / memory address width.
- `NODE_W`, 8: node word width, laid out as {feature idx, threshold}.
- `MEM_LAT`, 1: fixed memory read latency in cycles (1..4).

Ports:
- `clk`, in, 1: clock. Single clock domain.
- `rst`, in, 1: reset. Synchronous and active-high.
- `req`, in, `NUM_REQ`: per-stage read request. Held until granted.
- `reqIdx`, in, `NUM_REQ*IDX_W`: flattened node indices. Requester i occupies bits [i*IDX_W +: IDX_W].
- `gnt`, out, `NUM_REQ`: one-hot accept, combinational, same cycle as issue.
- `rspVal`, out, `NUM_REQ`: one-hot, one-cycle response valid.
- `rspData`, out, `NODE_W`: node word, broadcast to all stages. Valid only with `rspVal`.
- `memRdy`, out, 1: high when no configuration write occurred in the last `MEM_LAT`+1 cycles.
- `cfgWe`, in, 1: host write strobe.
- `cfgAddr`, in, `IDX_W`: host write address.
- `cfgData`, in, `NODE_W`: host write data.
- `memRd`, out, 1: memory read strobe.
- `memWe`, out, 1: memory write strobe.
- `memAddr`, out, `IDX_W`: memory address.
- `memWData`, out, `NODE_W`: memory write data.
- `memRData`, in, `NODE_W`: memory read data. Valid `MEM_LAT` cycles after `memRd`.
- `memStall`, in, 1: memory busy. No access is issued while high.

## Operation
- Issue rule, evaluated each cycle in this order:
  - If `rst`, nothing is issued.
  - Else if `memStall`, nothing is issued.
  - Else if `cfgWe`: `memWe`=1, `memAddr`=`cfgAddr`, `memWData`=`cfgData`, `gnt`=0.
  - Else if any `req` is high: grant exactly one requester, set `memRd`=1 and `memAddr`=`reqIdx` of the granted requester.
- Round-robin selection:
  - Register `lastGnt` holds the index of the last granted requester.
  - The search starts at `lastGnt`+1 and wraps modulo `NUM_REQ`.
  - `lastGnt` updates only on a grant.
  - Reset value of `lastGnt` is `NUM_REQ`-1, so requester 0 has first priority.
- Tag pipeline:
  - `MEM_LAT`+1 stages, each holding {valid, one-hot id}.
  - Stage 0 loads `gnt` (valid = |`gnt`).
  - When the tag reaches stage `MEM_LAT`, `memRData` is captured into the `rspData` register and the id drives `rspVal`.
- Responses are never stalled. A stage must accept `rspVal` in the cycle it is asserted.
- One request may be in flight per requester. A requester must not re-assert `req` until its `rspVal` arrives; the arbiter does not check this.
- `memRdy`:
  - Uses a counter that loads `MEM_LAT`+1 on `cfgWe` and decrements to 0.
  - `memRdy` = (counter == 0).
  - This keeps stages from reading a node being rewritten.
- No state machine beyond the round-robin pointer, the tag pipeline and the `memRdy` counter. The block is fully pipelined at 1 issue per cycle.

## Timing
- Cycle N: request granted; `gnt`, `memRd` and `memAddr` asserted combinationally.
- Cycle N+`MEM_LAT`: `memRData` is valid.
- Cycle N+`MEM_LAT`+1: `rspVal` and `rspData` are valid (registered).
- Total request-to-response latency: `MEM_LAT`+1 cycles.
- Back-to-back grants to different requesters produce back-to-back responses in grant order.
- Reset values:
  - Registered outputs: `rspVal`=0, `rspData`=0, `memRdy`=1.
  - Combinational outputs while `rst` is high: `gnt`, `memRd`, `memWe` are 0; `memAddr` and `memWData` are 0.
  - Internal: all tag stages invalid, counter 0.
- Reset mid-operation: all in-flight tags are dropped and no `rspVal` follows. Requesters re-issue.
- `cfgWe` and `req` in the same cycle: the write wins, no grant, and `lastGnt` is unchanged.
- `memStall` with `cfgWe` high: the write is not performed and the host must hold it. `memRdy` is unaffected.
- A single requester (one-hot `req`) is granted every eligible cycle regardless of `lastGnt`.

## Test plan
- Reset then single request: `req`=0001, `reqIdx[0]`=3, memory[3]=8'h06 -> `gnt`=0001 at cycle N, `memAddr`=3, `rspVal`=0001 and `rspData`=8'h06 at N+2 (`MEM_LAT`=1).
- All four requesting continuously after reset -> grant order 0,1,2,3,0; each `rspVal` follows its grant by 2 cycles, one response per cycle.
- `req`=1010 with `lastGnt`=1 -> grant 3, then 1. With `lastGnt`=3 -> grant 1, then 3 (wrap check).
- `cfgWe`=1 (addr 5, data 8'h16) coincident with `req`=0001 -> `memWe`=1, `gnt`=0, `memRdy` low for 2 cycles. Next cycle grant 0; a read of addr 5 returns 8'h16.
- `memStall` high for 3 cycles with `req`=0100 -> no `gnt`/`memRd` during the stall; grant in the first cycle after `memStall` falls.
- Grant at N, `rst` asserted at N+1 -> no `rspVal` at N+2. All outputs are at reset values and the grant order restarts at 0.
